// File: rtl/pll_seq_pkg.sv
// Shared encodings for the PLL lock sequencer and its status readback.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_t;

  localparam int RETRY_W = 4;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses RESETB, qualifies LOCK, releases system reset.
//
// state     | meaning
// PLL_RST   | RESETB held low for RST_CYCLES
// WAIT_LOCK | RESETB released, waiting for synchronized lock
// STABLE    | lock seen, counting consecutive locked cycles
// RUN       | lock qualified, system reset released
// FAIL      | retries exhausted, PLL held in reset until restart
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic               restart,
  input  logic               clear_status,
  output logic               pll_resetb,
  output logic               sys_reset,
  output logic               ready,
  output logic               failed,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         state
);

  localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
  localparam int               ATT_W     = $clog2(MAX_RETRIES + 2);
  localparam logic [ATT_W-1:0] ATT_MAX   = ATT_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  pll_state_t         state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [ATT_W-1:0]   att_q, att_nxt;
  logic               lock_s;
  logic               lock_drop;
  logic               retry_inc;
  logic               lock_lost_nxt;
  logic [RETRY_W-1:0] retry_base, retry_nxt;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    att_nxt   = att_q;
    lock_drop = 1'b0;
    retry_inc = 1'b0;
    if (restart) begin
      state_nxt = PLL_RST;
      cnt_nxt   = '0;
      att_nxt   = '0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == RST_TC) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
          end else if (cnt_q == LOCK_TC) begin
            cnt_nxt = '0;
            if (att_q < ATT_MAX) begin
              att_nxt   = att_q + 1'b1;
              retry_inc = 1'b1;
              state_nxt = PLL_RST;
            end else begin
              state_nxt = FAIL;
            end
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
        STABLE: begin
          // A dropout here restarts qualification but is not a retry.
          if (!lock_s) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt_q == STABLE_TC) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_nxt = PLL_RST;
            cnt_nxt   = '0;
            att_nxt   = '0;
            lock_drop = 1'b1;
          end
        end
        FAIL: ;
        default: begin
          state_nxt = PLL_RST;
          cnt_nxt   = '0;
        end
      endcase
    end

    // Set/increment takes precedence over a coincident clear.
    retry_base    = clear_status ? '0 : retry_count;
    retry_nxt     = (retry_inc && (retry_base != RETRY_SAT)) ? retry_base + 1'b1 : retry_base;
    lock_lost_nxt = lock_drop | (lock_lost & ~clear_status);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      att_q       <= '0;
      pll_resetb  <= 1'b0;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
      failed      <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      att_q       <= att_nxt;
      pll_resetb  <= !((state_nxt == PLL_RST) || (state_nxt == FAIL));
      sys_reset   <= (state_nxt != RUN);
      ready       <= (state_nxt == RUN);
      failed      <= (state_nxt == FAIL);
      lock_lost   <= lock_lost_nxt;
      retry_count <= retry_nxt;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed scoreboard bench for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset, pll_locked, restart, clear_status;
  logic       pll_resetb, sys_reset, ready, failed, lock_lost;
  logic [3:0] retry_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .CNT_W         (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_locked   (pll_locked),
    .restart      (restart),
    .clear_status (clear_status),
    .pll_resetb   (pll_resetb),
    .sys_reset    (sys_reset),
    .ready        (ready),
    .failed       (failed),
    .lock_lost    (lock_lost),
    .retry_count  (retry_count),
    .state        (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow observed %0d", obs);
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", e.tag, obs, e.exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    push({pfx, "_pll_resetb"}, 0);   check(32'(pll_resetb));
    push({pfx, "_sys_reset"}, 1);    check(32'(sys_reset));
    push({pfx, "_ready"}, 0);        check(32'(ready));
    push({pfx, "_failed"}, 0);       check(32'(failed));
    push({pfx, "_lock_lost"}, 0);    check(32'(lock_lost));
    push({pfx, "_retry_count"}, 0);  check(32'(retry_count));
    push({pfx, "_state"}, PLL_RST);  check(32'(state));
  endtask

  initial begin
    int n;
    int cyc;
    logic saw_stable, saw_abort;

    reset = 1'b1;
    pll_locked = 1'b1;
    restart = 1'b0;
    clear_status = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");

    // Power-up with lock tied high.
    reset = 1'b0;
    push("resetb_low_cycles", 4);
    n = 0;
    while (pll_resetb === 1'b0 && n < 20) begin n++; tick(); end
    check(32'(n));
    cyc = n;
    push("powerup_ready", 1);
    while (ready !== 1'b1 && cyc < 15) begin tick(); cyc++; end
    check(32'(ready));
    push("powerup_sys_reset", 0);   check(32'(sys_reset));
    push("powerup_retry_count", 0); check(32'(retry_count));
    push("powerup_state", RUN);     check(32'(state));

    // Lock loss in RUN for 3 cycles.
    pll_locked = 1'b0;
    push("lockloss_within_3", 1);
    n = 0;
    while (sys_reset !== 1'b1 && n < 10) begin tick(); n++; end
    check(32'(n <= 3));
    push("lockloss_ready", 0);     check(32'(ready));
    push("lockloss_lock_lost", 1); check(32'(lock_lost));
    push("lockloss_state", PLL_RST); check(32'(state));
    repeat (3 - ((n < 3) ? n : 3)) tick();
    pll_locked = 1'b1;
    push("relock_ready", 1);
    n = 0;
    while (ready !== 1'b1 && n < 30) begin tick(); n++; end
    check(32'(ready));
    push("relock_lock_lost_kept", 1); check(32'(lock_lost));

    // Lock glitches during STABLE, then returns.
    pll_locked = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    push("restart_state", PLL_RST);  check(32'(state));
    push("restart_pll_resetb", 0);   check(32'(pll_resetb));
    n = 0;
    while (state !== 3'(WAIT_LOCK) && n < 10) begin tick(); n++; end
    repeat (5) tick();
    pll_locked = 1'b1;
    saw_stable = 1'b0;
    repeat (3) begin
      tick();
      if (state === 3'(STABLE)) saw_stable = 1'b1;
    end
    pll_locked = 1'b0;
    saw_abort = 1'b0;
    n = 0;
    while (!saw_abort && n < 10) begin
      tick();
      n++;
      if (state === 3'(WAIT_LOCK) && saw_stable) saw_abort = 1'b1;
      else if (state === 3'(STABLE)) saw_stable = 1'b1;
    end
    push("stable_abort_to_wait", 1); check(32'(saw_abort));
    push("stable_abort_retry", 0);   check(32'(retry_count));
    pll_locked = 1'b1;
    n = 0;
    while (state !== 3'(STABLE) && n < 10) begin tick(); n++; end
    push("second_stable", STABLE); check(32'(state));
    push("ready_after_stable", 8);
    n = 0;
    while (ready !== 1'b1 && n < 20) begin tick(); n++; end
    check(32'(n));
    push("abort_retry_count", 0); check(32'(retry_count));

    // Lock never returns: retries exhaust into FAIL.
    pll_locked = 1'b0;
    n = 0;
    while (state !== 3'(FAIL) && n < 200) begin tick(); n++; end
    push("fail_state", FAIL);      check(32'(state));
    push("fail_failed", 1);        check(32'(failed));
    push("fail_retry_count", 2);   check(32'(retry_count));
    push("fail_pll_resetb", 0);    check(32'(pll_resetb));
    push("fail_sys_reset", 1);     check(32'(sys_reset));
    repeat (10) tick();
    push("fail_sticky", FAIL);     check(32'(state));

    restart = 1'b1;
    tick();
    restart = 1'b0;
    push("restart_failed", 0); check(32'(failed));
    push("restart_resetb_low_cycles", 4);
    n = 0;
    while (pll_resetb === 1'b0 && n < 20) begin n++; tick(); end
    check(32'(n));
    push("restart_wait_state", WAIT_LOCK); check(32'(state));
    push("timeout_cycles", 32);
    n = 0;
    while (state !== 3'(PLL_RST) && n < 40) begin tick(); n++; end
    check(32'(n));
    push("retry_count_after_timeout", 3); check(32'(retry_count));

    // clear_status coincident with a timeout retry.
    n = 0;
    while (pll_resetb !== 1'b1 && n < 10) begin tick(); n++; end
    repeat (31) tick();
    push("pre_timeout_state", WAIT_LOCK); check(32'(state));
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    push("clear_vs_inc_state", PLL_RST); check(32'(state));
    push("clear_vs_inc_retry", 1);       check(32'(retry_count));
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    push("clear_lock_lost", 0);   check(32'(lock_lost));
    push("clear_retry_count", 0); check(32'(retry_count));

    // Reset asserted mid-STABLE.
    pll_locked = 1'b1;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n = 0;
    while (state !== 3'(STABLE) && n < 20) begin tick(); n++; end
    repeat (2) tick();
    push("mid_stable_state", STABLE); check(32'(state));
    reset = 1'b1;
    tick();
    check_reset_vals("midreset");
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
